// File: rtl/tiff_stream_reader.sv
// tiff_stream_reader: parses an uncompressed big-endian RGB TIFF byte stream,
// recovers image size and strip location, then streams 24-bit raster pixels.
module tiff_stream_reader #(
  parameter int OFF_W   = 24,
  parameter int DIM_W   = 16,
  parameter int MAX_ENT = 16
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic [7:0]       r,
  output logic [7:0]       g,
  output logic [7:0]       b,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             frame_start,
  output logic             frame_done,
  output logic [DIM_W-1:0] xdim,
  output logic [DIM_W-1:0] ydim,
  output logic             hdr_error
);
  localparam int PCW = 2 * DIM_W;      // pixel counter width
  localparam int BCW = OFF_W + DIM_W;  // width of the byte-count consistency check

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_IFD_CNT, S_IFD_ENT, S_SKIP, S_PIXEL, S_ERR
  } state_t;

  state_t           state_q, state_d;
  logic [OFF_W-1:0] off_q, off_d;
  logic [3:0]       bcnt_q, bcnt_d;
  logic [23:0]      sh_q, sh_d;
  logic [31:0]      ptr_q, ptr_d;
  logic [15:0]      nent_q, nent_d, ent_q, ent_d;
  logic [15:0]      tag_q, tag_d, typ_q, typ_d;
  logic [31:0]      lx_q, lx_d, ly_q, ly_d, lcomp_q, lcomp_d;
  logic [31:0]      lstrip_q, lstrip_d, lspp_q, lspp_d, lbc_q, lbc_d;
  logic [DIM_W-1:0] xd_q, xd_d, yd_q, yd_d;
  logic [1:0]       pidx_q, pidx_d;
  logic [7:0]       rb_q, rb_d, gb_q, gb_d;
  logic [7:0]       r_q, r_d, g_q, g_d, b_q, b_d;
  logic             pv_q, pv_d, fs_q, fs_d, err_q, err_d;
  logic [PCW-1:0]   ld_q, ld_d, tk_q, tk_d;

  logic             accept, take, go_err, hdr_ok, last_byte;
  logic [31:0]      off_nx, word, val;
  logic [15:0]      half;
  logic [7:0]       magic;
  logic [PCW-1:0]   total;
  logic [BCW-1:0]   need_bc;

  assign total     = PCW'(xd_q) * PCW'(yd_q);
  assign off_nx    = 32'(off_q) + 32'd1;     // offset after the byte now being accepted
  assign word      = {sh_q, byte_in};
  assign half      = {sh_q[7:0], byte_in};
  assign accept    = byte_valid && byte_ready;
  assign take      = pv_q && pix_ready && (state_q == S_PIXEL) && !start;
  assign frame_done = take && (tk_q == total - PCW'(1));
  assign last_byte = (state_q == S_PIXEL) && (pidx_q == 2'd2) && (ld_q == total - PCW'(1));

  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign pix_valid   = pv_q;
  assign frame_start = fs_q;
  assign xdim        = xd_q;
  assign ydim        = yd_q;
  assign hdr_error   = err_q;

  // Byte acceptance: parse states always take bytes; pixel state is throttled by the output slot.
  always_comb begin
    byte_ready = 1'b0;
    case (state_q)
      S_HDR, S_IFD_CNT, S_IFD_ENT, S_SKIP: byte_ready = !start;
      S_PIXEL: byte_ready = !start && (ld_q != total) && (!pv_q || pix_ready);
      default: byte_ready = 1'b0;
    endcase
  end

  // Expected "MM\0*" magic byte for header offsets 0..3.
  always_comb begin
    case (off_q[1:0])
      2'd2:    magic = 8'h00;
      2'd3:    magic = 8'h2A;
      default: magic = 8'h4D;
    endcase
  end

  // Next-state and datapath: header/IFD parsing, strip skip, pixel assembly.
  always_comb begin
    state_d = state_q;   off_d = off_q;     bcnt_d = bcnt_q;   sh_d = sh_q;
    ptr_d = ptr_q;       nent_d = nent_q;   ent_d = ent_q;     tag_d = tag_q;
    typ_d = typ_q;       lx_d = lx_q;       ly_d = ly_q;       lcomp_d = lcomp_q;
    lstrip_d = lstrip_q; lspp_d = lspp_q;   lbc_d = lbc_q;     xd_d = xd_q;
    yd_d = yd_q;         pidx_d = pidx_q;   rb_d = rb_q;       gb_d = gb_q;
    r_d = r_q;           g_d = g_q;         b_d = b_q;         pv_d = pv_q;
    err_d = err_q;       ld_d = ld_q;       tk_d = tk_q;
    fs_d = 1'b0;
    go_err = 1'b0;
    hdr_ok = 1'b0;
    val = 32'd0;
    need_bc = '0;
    if (start) begin
      state_d = S_HDR;  off_d = '0;     bcnt_d = '0;    ptr_d = '0;
      lx_d = '0;        ly_d = '0;      lcomp_d = '0;   lstrip_d = '0;
      lspp_d = '0;      lbc_d = '0;     xd_d = '0;      yd_d = '0;
      pv_d = 1'b0;      err_d = 1'b0;   pidx_d = '0;    ld_d = '0;
      tk_d = '0;
    end else begin
      if (take) begin
        pv_d = 1'b0;
        tk_d = tk_q + PCW'(1);
      end
      if (accept) begin
        off_d = off_q + OFF_W'(1);
        sh_d  = {sh_q[15:0], byte_in};
      end
      case (state_q)
        S_HDR: if (accept) begin
          if (off_q < OFF_W'(4)) begin
            if (byte_in != magic) go_err = 1'b1;
          end else if (off_q == OFF_W'(7)) begin
            ptr_d = word;
            if (word < 32'd8) go_err = 1'b1;
            else if (word == 32'd8) state_d = S_IFD_CNT;
          end else if (off_q > OFF_W'(7) && off_nx == ptr_q) begin
            state_d = S_IFD_CNT;
          end
        end
        S_IFD_CNT: if (accept) begin
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'd1) begin
            bcnt_d = 4'd0;
            if (half == 16'd0 || 32'(half) > 32'(MAX_ENT)) go_err = 1'b1;
            else begin
              nent_d  = half;
              ent_d   = 16'd0;
              state_d = S_IFD_ENT;
            end
          end
        end
        S_IFD_ENT: if (accept) begin
          bcnt_d = bcnt_q + 4'd1;
          if (bcnt_q == 4'd1) tag_d = half;
          if (bcnt_q == 4'd3) typ_d = half;
          if (bcnt_q == 4'd11) begin
            bcnt_d = 4'd0;
            ent_d  = ent_q + 16'd1;
            // SHORT values sit in the first two bytes of the value field.
            val = (typ_q == 16'd3) ? {16'd0, word[31:16]} : word;
            if (typ_q == 16'd3 || typ_q == 16'd4) begin
              case (tag_q)
                16'h0100: lx_d     = val;
                16'h0101: ly_d     = val;
                16'h0103: lcomp_d  = val;
                16'h0111: lstrip_d = val;
                16'h0115: lspp_d   = val;
                16'h0117: lbc_d    = val;
                default:  ;
              endcase
            end
            if (ent_q == nent_q - 16'd1) begin
              need_bc = BCW'(lx_d[DIM_W-1:0]) * BCW'(ly_d[DIM_W-1:0]) * BCW'(3);
              hdr_ok = (lx_d != 32'd0) && (ly_d != 32'd0) &&
                       ((lx_d >> DIM_W) == 32'd0) && ((ly_d >> DIM_W) == 32'd0) &&
                       (lcomp_d == 32'd1) && (lspp_d == 32'd3) &&
                       (BCW'(lbc_d) == need_bc) && (lstrip_d >= off_nx);
              if (!hdr_ok) go_err = 1'b1;
              else begin
                xd_d    = lx_d[DIM_W-1:0];
                yd_d    = ly_d[DIM_W-1:0];
                pidx_d  = 2'd0;
                ld_d    = '0;
                tk_d    = '0;
                state_d = (lstrip_d == off_nx) ? S_PIXEL : S_SKIP;
              end
            end
          end
        end
        S_SKIP: if (accept && off_nx == lstrip_q) state_d = S_PIXEL;
        S_PIXEL: begin
          if (accept) begin
            pidx_d = pidx_q + 2'd1;
            case (pidx_q)
              2'd0: rb_d = byte_in;
              2'd1: gb_d = byte_in;
              default: begin
                pidx_d = 2'd0;
                r_d    = rb_q;
                g_d    = gb_q;
                b_d    = byte_in;
                pv_d   = 1'b1;
                fs_d   = (ld_q == '0);
                ld_d   = ld_q + PCW'(1);
              end
            endcase
          end
          if (frame_done) state_d = S_IDLE;
        end
        default: ;
      endcase
      // The offset counter may only hit its top value on the very last strip byte.
      if (accept && (&off_q) && !last_byte) go_err = 1'b1;
      if (go_err) begin
        state_d = S_ERR;
        err_d   = 1'b1;
        pv_d    = 1'b0;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; off_q <= '0;   bcnt_q <= '0;   sh_q <= '0;
      ptr_q <= '0;       nent_q <= '0;  ent_q <= '0;    tag_q <= '0;
      typ_q <= '0;       lx_q <= '0;    ly_q <= '0;     lcomp_q <= '0;
      lstrip_q <= '0;    lspp_q <= '0;  lbc_q <= '0;    xd_q <= '0;
      yd_q <= '0;        pidx_q <= '0;  rb_q <= '0;     gb_q <= '0;
      r_q <= '0;         g_q <= '0;     b_q <= '0;      pv_q <= 1'b0;
      fs_q <= 1'b0;      err_q <= 1'b0; ld_q <= '0;     tk_q <= '0;
    end else begin
      state_q <= state_d;   off_q <= off_d;   bcnt_q <= bcnt_d;   sh_q <= sh_d;
      ptr_q <= ptr_d;       nent_q <= nent_d; ent_q <= ent_d;     tag_q <= tag_d;
      typ_q <= typ_d;       lx_q <= lx_d;     ly_q <= ly_d;       lcomp_q <= lcomp_d;
      lstrip_q <= lstrip_d; lspp_q <= lspp_d; lbc_q <= lbc_d;     xd_q <= xd_d;
      yd_q <= yd_d;         pidx_q <= pidx_d; rb_q <= rb_d;       gb_q <= gb_d;
      r_q <= r_d;           g_q <= g_d;       b_q <= b_d;         pv_q <= pv_d;
      fs_q <= fs_d;         err_q <= err_d;   ld_q <= ld_d;       tk_q <= tk_d;
    end
  end
endmodule

// File: tb/tb_tiff_stream_reader.sv
// Directed testbench for tiff_stream_reader: builds TIFF images in a byte array,
// streams them in and checks pixels, geometry, pulses and error handling.
module tb_tiff_stream_reader;
  logic        pclk = 1'b0;
  logic        rst_n, start, byte_valid, pix_ready;
  logic [7:0]  byte_in;
  logic        byte_ready, pix_valid, frame_start, frame_done, hdr_error;
  logic [7:0]  r, g, b;
  logic [15:0] xdim, ydim;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  file [0:511];
  int          flen, strip;
  int          cons, pix_n, fs_n, fd_n;
  int          hk;
  logic        seen;

  tiff_stream_reader #(.OFF_W(24), .DIM_W(16), .MAX_ENT(16)) dut (
    .pclk(pclk), .rst_n(rst_n), .start(start),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .r(r), .g(g), .b(b), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .frame_start(frame_start), .frame_done(frame_done),
    .xdim(xdim), .ydim(ydim), .hdr_error(hdr_error)
  );

  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  task automatic put16(input int a, input int v);
    file[a]   = 8'(v >> 8);
    file[a+1] = 8'(v);
  endtask

  task automatic put32(input int a, input int v);
    put16(a, v >> 16);
    put16(a + 2, v);
  endtask

  task automatic ent(input int idx, input int tag, input int typ, input int val);
    int a;
    a = 18 + 12 * idx;
    put16(a, tag);
    put16(a + 2, typ);
    put32(a + 4, 1);
    if (typ == 3) begin
      put16(a + 8, val);
      put16(a + 10, 0);
    end else begin
      put32(a + 8, val);
    end
  endtask

  // Writer layout: IFD at 0x10 with 12 entries, strip at 0xC0, 4 trailing bytes after the strip.
  task automatic build(input int xd, input int yd, input int bc, input int comp,
                       input logic [7:0] first, input int seed);
    for (int i = 0; i < 512; i++) file[i] = 8'h00;
    file[0] = first; file[1] = 8'h4D; file[2] = 8'h00; file[3] = 8'h2A;
    put32(4, 16);
    put16(16, 12);
    ent(0,  'h0FE, 4, 0);
    ent(1,  'h100, 3, xd);
    ent(2,  'h101, 3, yd);
    ent(3,  'h102, 3, 'hA6);
    ent(4,  'h103, 3, comp);
    ent(5,  'h106, 3, 2);
    ent(6,  'h111, 4, 'hC0);
    ent(7,  'h115, 3, 3);
    ent(8,  'h116, 3, yd);
    ent(9,  'h117, 4, bc);
    ent(10, 'h115, 5, 9);      // unsupported type: must not override samples/pixel
    ent(11, 'h128, 3, 2);
    strip = 'hC0;
    for (int i = 0; i < xd * yd * 3; i++) file[strip + i] = 8'(seed + 7 * i);
    flen = strip + xd * yd * 3 + 4;
    for (int i = strip + xd * yd * 3; i < flen; i++) file[i] = 8'hEE;
  endtask

  task automatic do_start();
    @(negedge pclk);
    start = 1'b1; byte_valid = 1'b0; pix_ready = 1'b0;
    @(negedge pclk);
    start = 1'b0;
  endtask

  // Streams the file; stops after stop_pix pixels, budget cycles, or 8 cycles past done/error.
  task automatic run(input int stall, input int gaps, input int stop_pix,
                     input int budget, input int np);
    int          cyc;
    int          post;
    logic        held;
    logic [23:0] held_rgb;
    cyc = 0; post = 0; held = 1'b0; held_rgb = '0;
    cons = 0; pix_n = 0; fs_n = 0; fd_n = 0;
    while (cyc < budget && post < 8 && pix_n < stop_pix) begin
      @(negedge pclk);
      byte_valid = (cons < flen) && !(gaps != 0 && (cyc % 4) == 1);
      byte_in    = byte_valid ? file[cons] : 8'h00;
      pix_ready  = (stall == 0) || ((cyc % 3) == 0);
      #1;
      if (held) begin
        check("stall_valid", 40'(pix_valid), 40'd1);
        check("stall_rgb", 40'({r, g, b}), 40'(held_rgb));
      end
      if (frame_start) begin
        check("fs_with_pix0", 40'({pix_valid, 16'(pix_n)}), 40'({1'b1, 16'd0}));
        fs_n++;
      end
      if (frame_done) begin
        check("fd_on_last", 40'({pix_valid && pix_ready, 16'(pix_n + 1)}), 40'({1'b1, 16'(np)}));
        fd_n++;
      end
      if (byte_valid && byte_ready) cons++;
      if (pix_valid && pix_ready) begin
        if (pix_n < np)
          check("pixel", 40'({r, g, b}),
                40'({file[strip + 3*pix_n], file[strip + 3*pix_n + 1], file[strip + 3*pix_n + 2]}));
        else
          check("extra_pixel", 40'(pix_n), 40'(np));
        $display("pixel %0d rgb=%02h%02h%02h", pix_n, r, g, b);
        pix_n++;
        held = 1'b0;
      end else begin
        held     = pix_valid;
        held_rgb = {r, g, b};
      end
      if (fd_n != 0 || hdr_error) post++;
      cyc++;
    end
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; pix_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge pclk);
    #1;
    check("rst_byte_ready", 40'(byte_ready), 40'd0);
    check("rst_pix_valid", 40'(pix_valid), 40'd0);
    check("rst_pulses", 40'({frame_start, frame_done}), 40'd0);
    check("rst_hdr_error", 40'(hdr_error), 40'd0);
    check("rst_dims", 40'({xdim, ydim}), 40'd0);
    check("rst_rgb", 40'({r, g, b}), 40'd0);
    @(negedge pclk);
    rst_n = 1'b1; byte_valid = 1'b1; byte_in = 8'h4D;
    #1 check("idle_no_ready", 40'(byte_ready), 40'd0);

    // 1) 4x2 frame, downstream always ready.
    build(4, 2, 24, 1, 8'h4D, 'h10);
    do_start();
    run(0, 0, 1000, 600, 8);
    $display("test1 done: pixels=%0d consumed=%0d", pix_n, cons);
    check("t1_pixels", 40'(pix_n), 40'd8);
    check("t1_fs", 40'(fs_n), 40'd1);
    check("t1_fd", 40'(fd_n), 40'd1);
    check("t1_dims", 40'({xdim, ydim}), 40'({16'd4, 16'd2}));
    check("t1_hdr_error", 40'(hdr_error), 40'd0);
    check("t1_consumed", 40'(cons), 40'h0D8);
    check("t1_ready_after", 40'(byte_ready), 40'd0);

    // 2) Same file with downstream stalls and input gaps.
    do_start();
    run(1, 1, 1000, 1500, 8);
    $display("test2 done: pixels=%0d consumed=%0d", pix_n, cons);
    check("t2_pixels", 40'(pix_n), 40'd8);
    check("t2_fs", 40'(fs_n), 40'd1);
    check("t2_fd", 40'(fd_n), 40'd1);
    check("t2_consumed", 40'(cons), 40'h0D8);

    // 3) Little-endian marker: error after the first byte, then recovery.
    build(4, 2, 24, 1, 8'h49, 'h10);
    do_start();
    run(0, 0, 1000, 200, 0);
    $display("test3 done: consumed=%0d hdr_error=%0b", cons, hdr_error);
    check("t3_hdr_error", 40'(hdr_error), 40'd1);
    check("t3_consumed", 40'(cons), 40'd1);
    check("t3_ready", 40'(byte_ready), 40'd0);
    check("t3_no_pix", 40'({pix_valid, 16'(pix_n)}), 40'd0);
    build(4, 2, 24, 1, 8'h4D, 'h20);
    do_start();
    #1 check("t3_err_cleared", 40'(hdr_error), 40'd0);
    run(0, 0, 1000, 600, 8);
    check("t3_recover_pixels", 40'(pix_n), 40'd8);
    check("t3_recover_fd", 40'(fd_n), 40'd1);

    // 4) Inconsistent byte count, then unsupported compression.
    build(4, 2, 23, 1, 8'h4D, 'h10);
    do_start();
    run(0, 0, 1000, 400, 0);
    $display("test4a done: consumed=%0d hdr_error=%0b", cons, hdr_error);
    check("t4a_hdr_error", 40'(hdr_error), 40'd1);
    check("t4a_consumed", 40'(cons), 40'h0A2);
    check("t4a_no_pix", 40'(pix_n), 40'd0);
    build(4, 2, 24, 5, 8'h4D, 'h10);
    do_start();
    run(0, 0, 1000, 400, 0);
    $display("test4b done: consumed=%0d hdr_error=%0b", cons, hdr_error);
    check("t4b_hdr_error", 40'(hdr_error), 40'd1);
    check("t4b_consumed", 40'(cons), 40'h0A2);
    check("t4b_no_pix", 40'(pix_n), 40'd0);

    // 5) Restart while pixel 3 of 8 is held, then a 2x1 file.
    build(4, 2, 24, 1, 8'h4D, 'h40);
    do_start();
    run(0, 0, 3, 600, 8);
    hk = 0; seen = 1'b0;
    while (hk < 30 && !seen) begin
      @(negedge pclk);
      pix_ready  = 1'b0;
      byte_valid = (cons < flen);
      byte_in    = file[cons];
      #1;
      if (byte_valid && byte_ready) cons++;
      seen = pix_valid;
      hk++;
    end
    check("t5_held_valid", 40'(pix_valid), 40'd1);
    check("t5_held_rgb", 40'({r, g, b}), 40'({file[strip + 9], file[strip + 10], file[strip + 11]}));
    do_start();
    #1;
    check("t5_dropped", 40'(pix_valid), 40'd0);
    check("t5_dims_cleared", 40'({xdim, ydim}), 40'd0);
    build(2, 1, 6, 1, 8'h4D, 'h80);
    run(0, 0, 1000, 600, 2);
    $display("test5 done: pixels=%0d xdim=%0d", pix_n, xdim);
    check("t5_pixels", 40'(pix_n), 40'd2);
    check("t5_fd", 40'(fd_n), 40'd1);
    check("t5_fs", 40'(fs_n), 40'd1);
    check("t5_dims", 40'({xdim, ydim}), 40'({16'd2, 16'd1}));

    // 6) Asynchronous reset in the middle of the strip.
    build(4, 2, 24, 1, 8'h4D, 'h30);
    do_start();
    run(0, 0, 2, 600, 8);
    #2 rst_n = 1'b0;
    #1;
    check("t6_ready", 40'(byte_ready), 40'd0);
    check("t6_pix_valid", 40'(pix_valid), 40'd0);
    check("t6_rgb", 40'({r, g, b}), 40'd0);
    check("t6_dims", 40'({xdim, ydim}), 40'd0);
    check("t6_flags", 40'({frame_start, frame_done, hdr_error}), 40'd0);
    @(negedge pclk);
    rst_n = 1'b1; byte_valid = 1'b1; byte_in = 8'h4D; pix_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("t6_idle_ready", 40'(byte_ready), 40'd0);
      @(negedge pclk);
    end
    do_start();
    run(0, 0, 1000, 600, 8);
    $display("test6 done: pixels=%0d", pix_n);
    check("t6_recover_pixels", 40'(pix_n), 40'd8);
    check("t6_recover_fd", 40'(fd_n), 40'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
